// File: rtl/bcd_sec_counter_if.sv
// rtl/bcd_sec_counter_if.sv - control and digit bus of the BCD seconds counter (dir only with BCD_SEC_COUNTER_DOWN_EN)
interface bcd_sec_counter_if;
    logic       start_stop;
    logic       clear;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       tick;
    logic       wrap;
    logic       running;
`ifdef BCD_SEC_COUNTER_DOWN_EN
    logic       dir;

    modport master (
        output start_stop, clear, dir,
        input  ones, tens, tick, wrap, running
    );
    modport slave (
        input  start_stop, clear, dir,
        output ones, tens, tick, wrap, running
    );
`else
    modport master (
        output start_stop, clear,
        input  ones, tens, tick, wrap, running
    );
    modport slave (
        input  start_stop, clear,
        output ones, tens, tick, wrap, running
    );
`endif
endinterface

// File: rtl/bcd_sec_counter.sv
// rtl/bcd_sec_counter.sv - two-digit BCD seconds counter with prescaler and start/pause/clear; BCD_SEC_COUNTER_DOWN_EN adds dir
module bcd_sec_counter #(
    parameter int TICK_DIV  = 50000000,
    parameter int MAX_COUNT = 59
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    bcd_sec_counter_if.slave   bus
);
    localparam int              P_W      = $clog2(TICK_DIV);
    localparam logic [P_W-1:0]  P_LAST   = P_W'(TICK_DIV - 1);
    localparam logic [3:0]      MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0]      MAX_ONES = 4'(MAX_COUNT % 10);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t         r_state;
    logic [P_W-1:0] r_p;
    logic [3:0]     r_ones;
    logic [3:0]     r_tens;
    logic           r_start_q;
    logic           r_tick;
    logic           r_wrap;
    logic           r_running;

    logic           w_edge;
    logic           w_dir;
    logic [3:0]     w_next_ones;
    logic [3:0]     w_next_tens;
    logic           w_next_wrap;

    assign w_edge = bus.start_stop & ~r_start_q;

`ifdef BCD_SEC_COUNTER_DOWN_EN
    assign w_dir = bus.dir;
`else
    assign w_dir = 1'b0;
`endif

    // Next digit pair for one step; the terminal value wraps in either direction
    always_comb begin
        w_next_ones = r_ones;
        w_next_tens = r_tens;
        w_next_wrap = 1'b0;
        if (w_dir) begin
            if (r_ones == 4'd0 && r_tens == 4'd0) begin
                w_next_ones = MAX_ONES;
                w_next_tens = MAX_TENS;
                w_next_wrap = 1'b1;
            end else if (r_ones == 4'd0) begin
                w_next_ones = 4'd9;
                w_next_tens = r_tens - 4'd1;
            end else begin
                w_next_ones = r_ones - 4'd1;
            end
        end else begin
            if (r_ones == MAX_ONES && r_tens == MAX_TENS) begin
                w_next_ones = 4'd0;
                w_next_tens = 4'd0;
                w_next_wrap = 1'b1;
            end else if (r_ones == 4'd9) begin
                w_next_ones = 4'd0;
                w_next_tens = r_tens + 4'd1;
            end else begin
                w_next_ones = r_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_p       <= '0;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_start_q <= 1'b0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_start_q <= bus.start_stop;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            if (bus.clear) begin
                r_state   <= S_IDLE;
                r_p       <= '0;
                r_ones    <= 4'd0;
                r_tens    <= 4'd0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_p <= '0;
                        if (w_edge) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // A pause landing on the terminal prescale count keeps p there,
                        // so the withheld step fires on the first cycle after resume.
                        if (w_edge) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                            if (r_p != P_LAST)
                                r_p <= r_p + 1'b1;
                        end else if (r_p == P_LAST) begin
                            r_p    <= '0;
                            r_ones <= w_next_ones;
                            r_tens <= w_next_tens;
                            r_tick <= 1'b1;
                            r_wrap <= w_next_wrap;
                        end else begin
                            r_p <= r_p + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (w_edge) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_p       <= '0;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ones    = r_ones;
    assign bus.tens    = r_tens;
    assign bus.tick    = r_tick;
    assign bus.wrap    = r_wrap;
    assign bus.running = r_running;
endmodule

// File: tb/tb_bcd_sec_counter.sv
// tb/tb_bcd_sec_counter.sv - directed self-checking bench for bcd_sec_counter (TICK_DIV=4, MAX_COUNT=59)
module tb_bcd_sec_counter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [10:0] obs;
    logic [10:0] exp_v;

    bcd_sec_counter_if bus();

    bcd_sec_counter #(.TICK_DIV(4), .MAX_COUNT(59)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {tens, ones, tick, wrap, running}
    always_comb obs = {bus.tens, bus.ones, bus.tick, bus.wrap, bus.running};

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
        cyc(2);
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_state: got %h expected %h", obs, exp_v); end
        rst_n = 1'b1;
    endtask

    task automatic test_start;
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL start_running: got %h expected %h", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL start_no_early_tick %0d: got %h expected %h", i, obs, exp_v); end
        end
        cyc(1);
        exp_v = {4'd0, 4'd1, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL first_tick: got %h expected %h", obs, exp_v); end
        cyc(4);
        exp_v = {4'd0, 4'd2, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL second_tick: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_carry;
        cyc(28);
        exp_v = {4'd0, 4'd9, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reach_09: got %h expected %h", obs, exp_v); end
        cyc(4);
        exp_v = {4'd1, 4'd0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL carry_10: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_wrap;
        cyc(196);
        exp_v = {4'd5, 4'd9, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reach_59: got %h expected %h", obs, exp_v); end
        cyc(4);
        exp_v = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_00: got %h expected %h", obs, exp_v); end
        cyc(1);
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_one_cycle: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_pause;
        cyc(91);
        exp_v = {4'd2, 4'd3, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reach_23: got %h expected %h", obs, exp_v); end
        cyc(1);
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        exp_v = {4'd2, 4'd3, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL pause_enter: got %h expected %h", obs, exp_v); end
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL pause_frozen %0d: got %h expected %h", i, obs, exp_v); end
        end
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        exp_v = {4'd2, 4'd3, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL resume: got %h expected %h", obs, exp_v); end
        cyc(1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL resume_wait: got %h expected %h", obs, exp_v); end
        cyc(1);
        exp_v = {4'd2, 4'd4, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL resume_tick_24: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_hold;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clear_idle: got %h expected %h", obs, exp_v); end
        bus.start_stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_cmp++;
            if (bus.running !== 1'b1) begin n_err++; $display("FAIL hold_running %0d: got %b expected 1", i, bus.running); end
        end
        bus.start_stop = 1'b0;
        cyc(2);
        n_cmp++;
        if (bus.running !== 1'b1) begin n_err++; $display("FAIL hold_release: got %b expected 1", bus.running); end
    endtask

    task automatic test_pause_terminal;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        cyc(3);
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL pause_at_terminal: got %h expected %h", obs, exp_v); end
        cyc(3);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL pause_terminal_hold: got %h expected %h", obs, exp_v); end
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL terminal_resume: got %h expected %h", obs, exp_v); end
        cyc(1);
        exp_v = {4'd0, 4'd1, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL terminal_step: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_clear_edge;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        cyc(148);
        exp_v = {4'd3, 4'd7, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reach_37: got %h expected %h", obs, exp_v); end
        bus.clear = 1'b1;
        bus.start_stop = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clear_with_edge: got %h expected %h", obs, exp_v); end
        cyc(1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clear_edge_discarded: got %h expected %h", obs, exp_v); end
        bus.start_stop = 1'b0;
        cyc(4);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clear_stays_idle: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid;
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        cyc(11);
        exp_v = {4'd0, 4'd2, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL pre_reset_02: got %h expected %h", obs, exp_v); end
        rst_n = 1'b0;
        cyc(1);
        exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_mid: got %h expected %h", obs, exp_v); end
        rst_n = 1'b1;
        cyc(4);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_mid_idle: got %h expected %h", obs, exp_v); end
    endtask

`ifdef BCD_SEC_COUNTER_DOWN_EN
    task automatic test_down;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        bus.dir = 1'b1;
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
        cyc(4);
        exp_v = {4'd5, 4'd9, 1'b1, 1'b1, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL down_wrap_59: got %h expected %h", obs, exp_v); end
        cyc(4);
        exp_v = {4'd5, 4'd8, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL down_58: got %h expected %h", obs, exp_v); end
        bus.dir = 1'b0;
        cyc(4);
        exp_v = {4'd5, 4'd9, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL up_again_59: got %h expected %h", obs, exp_v); end
        cyc(4);
        exp_v = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL up_again_wrap: got %h expected %h", obs, exp_v); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
`ifdef BCD_SEC_COUNTER_DOWN_EN
        bus.dir = 1'b0;
`endif
        test_reset;
        test_start;
        test_carry;
        test_wrap;
        test_pause;
        test_hold;
        test_pause_terminal;
        test_clear_edge;
        test_reset_mid;
`ifdef BCD_SEC_COUNTER_DOWN_EN
        test_down;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
